const_mul23_recon: RTL and testbench

- Inverse of the constant-division-by-23 datapath: rebuilds the 64-bit dividend as x = 23*q + r from a quotient/remainder pair.
- Used to cross-check divider results and to regenerate operands downstream.
- Digit-serial, LSB-first: each cycle multiplies one DIGIT-bit slice of q by DIVISOR and adds the running carry.
- Valid/ready handshake on both input and output.

---
 rtl/const_div_pkg.sv | 28 ++
 rtl/mul23_digit_step.sv | 25 ++
 rtl/const_mul23_recon.sv | 96 +++++++++
 tb/tb_const_mul23_recon.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/const_div_pkg.sv
// rtl/const_div_pkg.sv - shared constants, clog2 and state enum for the divide-by-23 family
package const_div_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  localparam int WIDTH   = 64;
  localparam int DIVISOR = 23;
  localparam int DIGIT   = 4;
  localparam int RW      = clog2(DIVISOR);
  localparam int STEPS   = WIDTH / DIGIT;
  // One extra carry bit so an out-of-range remainder still propagates exactly.
  localparam int CW      = RW + 1;
  localparam int CNTW    = clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mul23_digit_step.sv
// rtl/mul23_digit_step.sv - one digit of d*DIVISOR + carry, built from constant shift-adds
module mul23_digit_step
  import const_div_pkg::*;
(
  input  logic [DIGIT-1:0] d,
  input  logic [CW-1:0]    c,
  output logic [DIGIT-1:0] lo,
  output logic [CW-1:0]    c_next
);

  localparam int PW = DIGIT + CW;
  localparam logic [RW-1:0] K = RW'(DIVISOR);

  logic [PW-1:0] p;

  always_comb begin
    p = PW'(c);
    for (int i = 0; i < RW; i++) begin
      if (K[i]) p = p + (PW'(d) << i);
    end
    lo     = p[DIGIT-1:0];
    c_next = p[PW-1:DIGIT];
  end

endmodule

// File: rtl/const_mul23_recon.sv
// rtl/const_mul23_recon.sv - digit-serial rebuild of x = 23*q + r with valid/ready on both sides
module const_mul23_recon
  import const_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_q,
  input  logic [RW-1:0]    in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic             out_ovf,
  output logic             out_rem_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_sh_q, q_sh_d;
  logic [WIDTH-1:0] x_sh_q, x_sh_d;
  logic [CW-1:0]    carry_q, carry_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             rem_err_q, rem_err_d;

  logic [DIGIT-1:0] step_lo;
  logic [CW-1:0]    step_c;

  mul23_digit_step u_step (
    .d      (q_sh_q[DIGIT-1:0]),
    .c      (carry_q),
    .lo     (step_lo),
    .c_next (step_c)
  );

  always_comb begin
    state_d   = state_q;
    q_sh_d    = q_sh_q;
    x_sh_d    = x_sh_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    rem_err_d = rem_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_sh_d    = in_q;
          carry_d   = CW'(in_r);
          x_sh_d    = '0;
          cnt_d     = '0;
          rem_err_d = (in_r >= RW'(DIVISOR));
          state_d   = RUN;
        end
      end
      RUN: begin
        // Result digits enter at the top and shift down, so after STEPS they sit LSB-aligned.
        x_sh_d  = {step_lo, x_sh_q[WIDTH-1:DIGIT]};
        q_sh_d  = q_sh_q >> DIGIT;
        carry_d = step_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNTW'(STEPS - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d   = IDLE;
          rem_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      q_sh_q    <= '0;
      x_sh_q    <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      rem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_sh_q    <= q_sh_d;
      x_sh_q    <= x_sh_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      rem_err_q <= rem_err_d;
    end
  end

  // Result flags are forced low outside DONE so partial state never leaks out.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_x       = out_valid ? x_sh_q : '0;
  assign out_ovf     = out_valid && (carry_q != '0);
  assign out_rem_err = out_valid && rem_err_q;

endmodule

// File: tb/tb_const_mul23_recon.sv
// tb/tb_const_mul23_recon.sv - directed bench for const_mul23_recon with a wide-arithmetic reference model
module tb_const_mul23_recon;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_q;
  logic [4:0]  in_r;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_x;
  logic        out_ovf;
  logic        out_rem_err;

  int checks;
  int failures;

  typedef struct {
    logic [63:0] x;
    logic        ovf;
    logic        rem_err;
  } exp_t;

  exp_t exp_q[$];

  const_mul23_recon dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_q        (in_q),
    .in_r        (in_r),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_ovf     (out_ovf),
    .out_rem_err (out_rem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [63:0] q, input logic [4:0] r);
    logic [127:0] full;
    exp_t e;
    full      = 128'(q) * 128'd23 + 128'(r);
    e.x       = full[63:0];
    e.ovf     = (full[127:64] != 128'd0);
    e.rem_err = (r >= 5'd23);
    return e;
  endfunction

  // Compare process: every settled cycle, outputs must match the model head or be idle zeros.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else begin
            check("model_x", out_x, exp_q[0].x);
            check("model_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
            check("model_rem_err", 64'(out_rem_err), 64'(exp_q[0].rem_err));
            check("in_ready_in_done", 64'(in_ready), 64'd0);
            if (out_ready) void'(exp_q.pop_front());
          end
        end else begin
          check("idle_x_zero", out_x, 64'd0);
          check("idle_flags_zero", {62'd0, out_ovf, out_rem_err}, 64'd0);
        end
      end
    end
  end

  // Offers one pair, measures latency, holds DONE for `hold` cycles and pins a literal result.
  task automatic run_pair(input logic [63:0] q, input logic [4:0] r, input int hold,
                          input logic [63:0] lit_x, input logic lit_ovf, input logic lit_rem);
    int lat;
    logic [63:0] x0;
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_q     = q;
    in_r     = r;
    exp_q.push_back(model(q, r));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_q     = 64'hDEAD_BEEF_0000_1234;
    in_r     = 5'd3;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == 5) in_valid = 1'b1;
      if (lat == 6) in_valid = 1'b0;
      if (lat == 5) check("in_ready_in_run", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd16);
    check("literal_x", out_x, lit_x);
    check("literal_ovf", 64'(out_ovf), 64'(lit_ovf));
    check("literal_rem_err", 64'(out_rem_err), 64'(lit_rem));
    x0 = out_x;
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 2);
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_x_stable", out_x, x0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("exit_valid_low", 64'(out_valid), 64'd0);
    check("exit_flags_low", {62'd0, out_ovf, out_rem_err}, 64'd0);
    check("exit_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("no_second_capture", 64'(in_ready), 64'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_q      = '0;
    in_r      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_x", out_x, 64'd0);
    check("reset_flags", {62'd0, out_ovf, out_rem_err}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_pair(64'd0, 5'd0, 0, 64'd0, 1'b0, 1'b0);
    run_pair(64'd1, 5'd22, 0, 64'd45, 1'b0, 1'b0);
    run_pair(64'd0, 5'd7, 0, 64'd7, 1'b0, 1'b0);
    run_pair(64'd802032351030850070, 5'd5, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_pair(64'd802032351030850070, 5'd6, 10, 64'd0, 1'b1, 1'b0);
    run_pair(64'd2, 5'd23, 0, 64'd69, 1'b0, 1'b1);
    run_pair(64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 3, 64'hFFFF_FFFF_FFFF_FFFF * 64'd23 + 64'd31, 1'b1, 1'b1);
    run_pair(64'h0123_4567_89AB_CDEF, 5'd11, 1, 64'h0123_4567_89AB_CDEF * 64'd23 + 64'd11, 1'b0, 1'b0);

    // Abort a conversion partway through; its result must never appear.
    in_valid = 1'b1;
    in_q     = 64'd5;
    in_r     = 5'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrun_in_ready", 64'(in_ready), 64'd1);
    check("midrun_out_valid", 64'(out_valid), 64'd0);
    check("midrun_out_x", out_x, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("midrun_still_idle", 64'(in_ready), 64'd1);
    run_pair(64'd3, 5'd1, 0, 64'd70, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("model_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
